// File: rtl/fir_ctrl_if.sv
// rtl/fir_ctrl_if.sv - sample-in / result-out stream bundle for the FIR sequencer
//
// Signals:
//   strm_data, strm_valid  sample offered by the input stage (one-cycle valid)
//   fir_ready              sequencer can take a sample
//   sm_tvalid, sm_tdata,
//   sm_tlast, sm_tready    result stream towards the output
// master = sequencer side, slave = surrounding stream stages.
interface fir_ctrl_if #(
    parameter int DW = 32
);
    logic [DW-1:0] strm_data;
    logic          strm_valid;
    logic          fir_ready;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;

    modport master (
        input  strm_data, strm_valid, sm_tready,
        output fir_ready, sm_tvalid, sm_tdata, sm_tlast
    );

    modport slave (
        output strm_data, strm_valid, sm_tready,
        input  fir_ready, sm_tvalid, sm_tdata, sm_tlast
    );
endinterface

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - FIR engine sequencer (start/idle/done, data clear, MAC walk, result output)
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   cfg_start, cfg_data_length  run request and samples per run
//   ap_start/ap_idle/ap_done run protocol towards input stage / config block
//   outfinish                low while a result waits in the output register
//   strm (fir_ctrl_if)       sample input and result output streams
//   tap_*                    tap RAM port (byte address, 1-cycle read latency)
//   data_*                   data RAM port (byte address, 1-cycle read latency)
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_start,
    input  logic [31:0]            cfg_data_length,
    output logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   outfinish,
    fir_ctrl_if.master             strm,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do
);
    localparam int IW = $clog2(Tape_Num + 1);
    localparam logic [IW-1:0] LAST = IW'(Tape_Num - 1);
    localparam logic [IW-1:0] TAPS = IW'(Tape_Num);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_MAC,
        S_OUT
    } state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          idx;      // clear index in CLEAR, tap index j in MAC
    logic [IW-1:0]          ptr;      // slot of the newest sample
    logic [31:0]            len;
    logic [31:0]            count;
    logic [pDATA_WIDTH-1:0] acc;
    logic [pDATA_WIDTH-1:0] result;
    logic                   done_q;

    logic [IW-1:0]          rd_idx;
    logic [pDATA_WIDTH-1:0] prod;
    logic [pDATA_WIDTH-1:0] acc_sum;
    logic                   last_result;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] i);
        return pADDR_WIDTH'(i) << 2;
    endfunction

    // Slot of sample x[n-j]; arithmetic wraps mod 2^IW, which is exact
    // because the true result always lies in 0..Tape_Num-1.
    assign rd_idx      = (ptr >= idx) ? (ptr - idx) : (ptr + TAPS - idx);
    // Low bits of a product are identical for signed and unsigned operands.
    assign prod        = $signed(tap_Do) * $signed(data_Do);
    assign acc_sum     = acc + prod;
    assign last_result = (count == len);

    assign ap_idle        = (state == S_IDLE);
    assign ap_done        = done_q;
    assign outfinish      = (state != S_OUT);
    assign strm.sm_tvalid = (state == S_OUT);
    assign strm.sm_tlast  = (state == S_OUT) && last_result;
    assign strm.sm_tdata  = result;

    always_comb begin
        state_nx       = state;
        ap_start       = 1'b0;
        strm.fir_ready = 1'b0;
        tap_EN         = 1'b0;
        tap_A          = '0;
        data_EN        = 1'b0;
        data_WE        = 4'h0;
        data_A         = '0;
        data_Di        = '0;
        case (state)
            S_IDLE: begin
                if (cfg_start && (cfg_data_length != 32'd0)) begin
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                data_EN = 1'b1;
                data_WE = 4'hF;
                data_A  = word_addr(idx);
                if (idx == LAST) begin
                    ap_start = 1'b1;
                    state_nx = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                strm.fir_ready = !strm.strm_valid;
                if (strm.strm_valid) begin
                    data_EN  = 1'b1;
                    data_WE  = 4'hF;
                    data_A   = word_addr(ptr);
                    data_Di  = strm.strm_data;
                    state_nx = S_MAC;
                end
            end
            S_MAC: begin
                // Reads are issued for j<Tape_Num; the product of read j
                // arrives one cycle later, so the walk takes one extra cycle.
                if (idx != TAPS) begin
                    tap_EN  = 1'b1;
                    tap_A   = word_addr(idx);
                    data_EN = 1'b1;
                    data_A  = word_addr(rd_idx);
                end else begin
                    state_nx = S_OUT;
                end
            end
            S_OUT: begin
                if (strm.sm_tready) begin
                    state_nx = last_result ? S_IDLE : S_WAIT_IN;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            ptr    <= '0;
            len    <= '0;
            count  <= '0;
            acc    <= '0;
            result <= '0;
            done_q <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (cfg_start && (cfg_data_length != 32'd0)) begin
                        len    <= cfg_data_length;
                        done_q <= 1'b0;
                        idx    <= '0;
                        ptr    <= '0;
                        count  <= '0;
                    end
                end
                S_CLEAR: begin
                    idx <= (idx == LAST) ? '0 : idx + IW'(1);
                end
                S_WAIT_IN: begin
                    if (strm.strm_valid) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                S_MAC: begin
                    if (idx != TAPS) begin
                        idx <= idx + IW'(1);
                        if (idx != '0) begin
                            acc <= acc_sum;
                        end
                    end else begin
                        acc    <= acc_sum;
                        result <= acc_sum;
                        ptr    <= (ptr == LAST) ? '0 : ptr + IW'(1);
                        count  <= count + 32'd1;
                    end
                end
                S_OUT: begin
                    if (strm.sm_tready && last_result) begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb/tb_fir_ctrl.sv - bench for fir_ctrl: vector table, random runs vs convolution model, corner sequences
module tb_fir_ctrl;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int N  = 11;

    typedef struct packed {
        logic [31:0]           len;
        logic [N-1:0][31:0]    taps;
        logic [15:0][31:0]     x;
        logic [15:0][31:0]     y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [31:0]   cfg_data_length = 32'd0;
    logic          ap_start, ap_idle, ap_done, outfinish;
    logic          tap_EN, data_EN;
    logic [3:0]    data_WE;
    logic [AW-1:0] tap_A, data_A;
    logic [DW-1:0] tap_Do, data_Do, data_Di;

    fir_ctrl_if #(.DW(DW)) bus ();

    fir_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_data_length (cfg_data_length),
        .ap_start        (ap_start),
        .ap_idle         (ap_idle),
        .ap_done         (ap_done),
        .outfinish       (outfinish),
        .strm            (bus),
        .tap_EN          (tap_EN),
        .tap_A           (tap_A),
        .tap_Do          (tap_Do),
        .data_EN         (data_EN),
        .data_WE         (data_WE),
        .data_A          (data_A),
        .data_Di         (data_Di),
        .data_Do         (data_Do)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] tap_mem [N];
    logic [DW-1:0] data_mem[N];
    int            wr_log[$];
    int            cyc = 0;
    int            n_start = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ap_start) n_start <= n_start + 1;
        if (tap_EN) tap_Do <= (int'(tap_A >> 2) < N) ? tap_mem[int'(tap_A >> 2)] : 32'hDEAD_BEEF;
        if (data_EN) begin
            data_Do <= (int'(data_A >> 2) < N) ? data_mem[int'(data_A >> 2)] : 32'hDEAD_BEEF;
            if (data_WE != 4'h0) begin
                wr_log.push_back(int'(data_A));
                if (data_WE == 4'hF && int'(data_A >> 2) < N) data_mem[int'(data_A >> 2)] <= data_Di;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: y[n] = sum_k tap[k] * x[n-k] over the run, x before the run = 0, 32-bit wrap.
    function automatic logic [31:0] model_y(input vec_t v, input int n);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < N; k++) begin
            if (n - k >= 0) s = s + v.taps[k] * v.x[n - k];
        end
        return s;
    endfunction

    task automatic run_vec(input vec_t v, input string tag, input int bp_idx,
                           input bit mac_start, input bit chk_tput);
        int w;
        int t_drive;
        int starts0;
        bit last;
        for (int k = 0; k < N; k++) tap_mem[k] = v.taps[k];
        starts0 = n_start;
        @(negedge clk);
        cfg_data_length = v.len;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_data_length = $urandom;
        t_drive = cyc;
        for (int i = 0; i < int'(v.len); i++) begin
            w = 0;
            while (!bus.fir_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!bus.fir_ready) begin
                check($sformatf("%s ready_timeout s%0d", tag, i), 32'd0, 32'd1);
                return;
            end
            if (chk_tput && i == 1) check($sformatf("%s throughput", tag), cyc - t_drive, N + 3);
            if (bp_idx == i) bus.sm_tready = 1'b0;
            bus.strm_data  = v.x[i];
            bus.strm_valid = 1'b1;
            t_drive = cyc;
            @(negedge clk);
            bus.strm_valid = 1'b0;
            if (mac_start && i == 0) begin
                repeat (2) @(negedge clk);
                cfg_data_length = 32'd1;
                cfg_start = 1'b1;
                @(negedge clk);
                cfg_start = 1'b0;
            end
            w = 0;
            while (!bus.sm_tvalid && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!bus.sm_tvalid) begin
                check($sformatf("%s tvalid_timeout s%0d", tag, i), 32'd0, 32'd1);
                return;
            end
            if (bp_idx == i) begin
                repeat (5) begin
                    @(negedge clk);
                    check($sformatf("%s bp_tdata", tag), bus.sm_tdata, v.y[i]);
                    check($sformatf("%s bp_tvalid", tag), bus.sm_tvalid, 1);
                    check($sformatf("%s bp_outfinish", tag), outfinish, 0);
                    check($sformatf("%s bp_fir_ready", tag), bus.fir_ready, 0);
                end
                bus.sm_tready = 1'b1;
            end
            last = (i == int'(v.len) - 1);
            check($sformatf("%s tdata r%0d", tag, i), bus.sm_tdata, v.y[i]);
            check($sformatf("%s tlast r%0d", tag, i), bus.sm_tlast, last);
            @(negedge clk);
            check($sformatf("%s no_dup r%0d", tag, i), bus.sm_tvalid, 0);
        end
        check($sformatf("%s ap_done", tag), ap_done, 1);
        check($sformatf("%s ap_idle", tag), ap_idle, 1);
        check($sformatf("%s ap_start_pulses", tag), n_start - starts0, 1);
    endtask

    vec_t tbl[4];
    vec_t rv;
    int   s0;
    int   exp_a;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.strm_data  = '0;
        bus.strm_valid = 1'b0;
        bus.sm_tready  = 1'b1;
        for (int k = 0; k < N; k++) tap_mem[k] = '0;

        // Directed vectors: impulse, wrap, arithmetic wrap, post-reset restart.
        for (int t = 0; t < 4; t++) tbl[t] = '0;
        tbl[0].len = 15;
        for (int k = 0; k < N; k++) tbl[0].taps[k] = 32'(k + 1);
        tbl[0].x[0] = 32'd1;
        for (int i = 0; i < N; i++) tbl[0].y[i] = 32'(i + 1);
        tbl[1].len = 13;
        for (int k = 0; k < N; k++) tbl[1].taps[k] = 32'd1;
        for (int i = 0; i < 13; i++) begin
            tbl[1].x[i] = 32'd1;
            tbl[1].y[i] = (i < N) ? 32'(i + 1) : 32'd11;
        end
        tbl[2].len = 1;
        tbl[2].taps[0] = 32'hFFFF_FFFE;
        tbl[2].x[0] = 32'h7FFF_FFFF;
        tbl[2].y[0] = 32'h0000_0002;
        tbl[3].len = 2;
        for (int k = 0; k < N; k++) tbl[3].taps[k] = 32'(k + 1);
        tbl[3].x[0] = 32'd5;
        tbl[3].y[0] = 32'd5;
        tbl[3].y[1] = 32'd10;

        // Reset hold.
        repeat (3) @(negedge clk);
        check("rst ap_idle", ap_idle, 1);
        check("rst fir_ready", bus.fir_ready, 0);
        check("rst sm_tvalid", bus.sm_tvalid, 0);
        check("rst ap_done", ap_done, 0);
        check("rst data_WE", data_WE, 0);
        check("rst ap_start", ap_start, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_start ap_idle", ap_idle, 1);

        // Zero-length start is ignored.
        s0 = wr_log.size();
        cfg_data_length = 32'd0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        check("len0 ap_idle", ap_idle, 1);
        check("len0 no_writes", wr_log.size() - s0, 0);

        run_vec(tbl[0], "impulse", -1, 1'b0, 1'b1);

        s0 = wr_log.size();
        run_vec(tbl[1], "wrap", -1, 1'b0, 1'b0);
        check("wrap write_count", wr_log.size() - s0, 24);
        for (int n = 0; n < 24 && s0 + n < wr_log.size(); n++) begin
            exp_a = (n < N) ? 4 * n : 4 * ((n - N) % N);
            check($sformatf("wrap data_A w%0d", n), wr_log[s0 + n], exp_a);
        end

        run_vec(tbl[0], "backpressure", 2, 1'b0, 1'b0);
        run_vec(tbl[2], "arith", -1, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rv = '0;
            rv.len = 32'($urandom_range(1, 16));
            for (int k = 0; k < N; k++) rv.taps[k] = (r < 3) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
            for (int i = 0; i < 16; i++) rv.x[i] = (r < 3) ? 32'($urandom_range(0, 200)) : $urandom;
            for (int i = 0; i < 16; i++) rv.y[i] = model_y(rv, i);
            run_vec(rv, $sformatf("rand%0d", r), (r == 4) ? int'($urandom_range(0, 3)) : -1, 1'b0, 1'b0);
        end

        // Reset in the middle of a MAC walk.
        for (int k = 0; k < N; k++) tap_mem[k] = 32'(k + 1);
        @(negedge clk);
        cfg_data_length = 32'd5;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (40) begin
            if (!bus.fir_ready) @(negedge clk);
        end
        check("abort reached_wait_in", bus.fir_ready, 1);
        bus.strm_data  = 32'd9;
        bus.strm_valid = 1'b1;
        @(negedge clk);
        bus.strm_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        s0 = wr_log.size();
        @(negedge clk);
        check("abort ap_idle", ap_idle, 1);
        check("abort fir_ready", bus.fir_ready, 0);
        check("abort sm_tvalid", bus.sm_tvalid, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort quiet sm_tvalid", bus.sm_tvalid, 0);
        check("abort quiet ap_idle", ap_idle, 1);
        check("abort no_writes", wr_log.size() - s0, 0);

        run_vec(tbl[3], "restart", -1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
